stopwatch_lap_core: RTL and testbench

//  Parametrised successor of the team's stopwatch counter core. Holds a BCD time hh:mm:ss.cc

---
 rtl/stopwatch_lap_core.sv | 193 +++++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_core.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_core
//   BCD stopwatch core that holds hh:mm:ss.cc. An internal prescaler turns
//   CLK_DIV enabled clocks into one centisecond tick. The core counts up, or
//   counts down and stops at zero. Up to N_LAPS split captures go into a lap
//   memory, and any stored lap can be recalled for display.
//
// Ports
//   clk_milisec  in   system clock, rising edge only
//   rst          in   synchronous active-high reset
//   en           in   run enable (0 freezes prescaler and time)
//   down         in   0 = count up, 1 = count down
//   load         in   1-cycle strobe: time <= preset, clears laps and flags
//   preset       in   BCD {hr1,hr0,min1,min0,sec1,sec0,cent1,cent0}
//   split        in   level input, rising edge captures a lap
//   view         in   0 = live time, 1 = lap selected by lap_sel
//   lap_sel      in   lap index shown when view = 1
//   o_time       out  displayed BCD value, same packing as preset
//   lap_count    out  number of stored laps, 0..N_LAPS
//   lap_full     out  lap_count == N_LAPS
//   lap_ovf      out  sticky: a split edge arrived while full
//   done         out  sticky: countdown reached 00:00:00.00
//   tick         out  registered 1-cycle pulse for each time update
//
// Handshake: there is no valid/ready flow. load and split edges act in the
// cycle they are seen. load wins over tick and split. rst wins over everything.
// -----------------------------------------------------------------------------
module stopwatch_lap_core #(
  parameter int CLK_DIV = 100,
  parameter int N_LAPS  = 4,
  parameter int HR_WRAP = 99
) (
  input  logic                         clk_milisec,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         down,
  input  logic                         load,
  input  logic [31:0]                  preset,
  input  logic                         split,
  input  logic                         view,
  input  logic [$clog2(N_LAPS)-1:0]    lap_sel,
  output logic [31:0]                  o_time,
  output logic [$clog2(N_LAPS+1)-1:0]  lap_count,
  output logic                         lap_full,
  output logic                         lap_ovf,
  output logic                         done,
  output logic                         tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(N_LAPS);
  localparam int CW = $clog2(N_LAPS + 1);

  localparam logic [3:0] HR1 = 4'(HR_WRAP / 10);
  localparam logic [3:0] HR0 = 4'(HR_WRAP % 10);

  // Highest value each digit may hold, nibble 0 = cent0 ... nibble 7 = hr1.
  localparam logic [31:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  // Last value before the up-count wraps to zero.
  localparam logic [31:0] TIME_TOP  = {HR1, HR0, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  logic [31:0]   r_time;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_laps [N_LAPS];
  logic [CW-1:0] r_lap_count;
  logic          r_split_q;
  logic          r_armed;
  logic          r_ovf;
  logic          r_done;
  logic          r_tick;

  logic [31:0]   w_time_up;
  logic [31:0]   w_time_dn;
  logic          w_time_zero;
  logic          w_presc_last;
  logic          w_split_edge;
  logic          w_lap_room;

  // BCD increment with ripple carry through the digit ranges.
  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= DIGIT_MAX[i*4 +: 4]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    if (t == TIME_TOP) r = '0;
    return r;
  endfunction

  // BCD decrement with ripple borrow. Only used when t is non-zero.
  function automatic logic [31:0] bcd_dec(input logic [31:0] t);
    logic [31:0] r;
    logic        b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = DIGIT_MAX[i*4 +: 4];
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    w_time_up    = bcd_inc(r_time);
    w_time_dn    = bcd_dec(r_time);
    w_time_zero  = (r_time == 32'h0);
    w_presc_last = en && (r_presc == PW'(CLK_DIV - 1));
    // r_armed masks the first cycle after reset. A split held high through
    // reset must not look like a fresh edge when reset releases.
    w_split_edge = split && !r_split_q && r_armed;
    w_lap_room   = (r_lap_count < CW'(N_LAPS));
  end

  always_ff @(posedge clk_milisec) begin
    if (rst) begin
      r_time      <= '0;
      r_presc     <= '0;
      r_lap_count <= '0;
      r_split_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_tick      <= 1'b0;
      for (int i = 0; i < N_LAPS; i++) r_laps[i] <= '0;
    end else begin
      r_split_q <= split;
      r_armed   <= 1'b1;
      r_tick    <= 1'b0;
      if (load) begin
        r_time      <= preset;
        r_presc     <= '0;
        r_lap_count <= '0;
        r_ovf       <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        if (en) r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
        if (w_presc_last) begin
          r_tick <= 1'b1;
          if (down) begin
            // Countdown stops at zero. A tick at zero only asserts done.
            if (w_time_zero) begin
              r_done <= 1'b1;
            end else begin
              r_time <= w_time_dn;
              if (w_time_dn == 32'h0) r_done <= 1'b1;
            end
          end else begin
            r_time <= w_time_up;
          end
        end
        // A capture takes the pre-update time when it shares a cycle with a tick.
        if (w_split_edge) begin
          if (w_lap_room) begin
            r_laps[r_lap_count[SW-1:0]] <= r_time;
            r_lap_count                 <= r_lap_count + CW'(1);
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    o_time = r_time;
    if (view) begin
      if (CW'(lap_sel) < r_lap_count) o_time = r_laps[lap_sel];
      else                            o_time = 32'h0;
    end
  end

  assign lap_count = r_lap_count;
  assign lap_full  = (r_lap_count == CW'(N_LAPS));
  assign lap_ovf   = r_ovf;
  assign done      = r_done;
  assign tick      = r_tick;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
module tb_stopwatch_lap_core;
  localparam int CLK_DIV = 4;
  localparam int N_LAPS  = 4;
  localparam int HR_WRAP = 99;
  localparam int MAXCS   = (HR_WRAP + 1) * 360000;

  // ---------------- clock / reset ----------------
  logic clk_milisec = 1'b0;
  always #5 clk_milisec = ~clk_milisec;

  logic        rst, en, down, load, split, view;
  logic [31:0] preset;
  logic [1:0]  lap_sel;
  logic [31:0] o_time;
  logic [2:0]  lap_count;
  logic        lap_full, lap_ovf, done, tick;

  stopwatch_lap_core #(.CLK_DIV(CLK_DIV), .N_LAPS(N_LAPS), .HR_WRAP(HR_WRAP)) dut (
    .clk_milisec(clk_milisec), .rst(rst), .en(en), .down(down), .load(load),
    .preset(preset), .split(split), .view(view), .lap_sel(lap_sel),
    .o_time(o_time), .lap_count(lap_count), .lap_full(lap_full),
    .lap_ovf(lap_ovf), .done(done), .tick(tick)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model (time as plain centiseconds) ----------------
  int m_t;
  int m_presc;
  int m_laps[$];
  bit m_ovf, m_done, m_tick, m_sq, m_armed;

  function automatic logic [31:0] cs2bcd(input int cs);
    int h, m, s, c;
    h = cs / 360000; m = (cs / 6000) % 60; s = (cs / 100) % 60; c = cs % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int bcd2cs(input logic [31:0] p);
    int h, m, s, c;
    h = int'(p[31:28]) * 10 + int'(p[27:24]);
    m = int'(p[23:20]) * 10 + int'(p[19:16]);
    s = int'(p[15:12]) * 10 + int'(p[11:8]);
    c = int'(p[7:4])   * 10 + int'(p[3:0]);
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [31:0] exp_disp();
    if (!view) return cs2bcd(m_t);
    if (int'(lap_sel) < m_laps.size()) return cs2bcd(m_laps[lap_sel]);
    return 32'h0;
  endfunction

  // ---------------- driver: advance one clock, model follows the spec rules ----------------
  task automatic cycle();
    int  old_t;
    bit  edge_seen, tk;
    if (rst) begin
      m_t = 0; m_presc = 0; m_laps.delete();
      m_ovf = 0; m_done = 0; m_tick = 0; m_sq = 0; m_armed = 0;
    end else begin
      edge_seen = split && !m_sq && m_armed;
      m_sq = split; m_armed = 1; m_tick = 0;
      if (load) begin
        m_t = bcd2cs(preset); m_presc = 0; m_laps.delete();
        m_ovf = 0; m_done = 0;
      end else begin
        tk = en && (m_presc == CLK_DIV - 1);
        if (en) m_presc = tk ? 0 : m_presc + 1;
        old_t = m_t;
        if (tk) begin
          m_tick = 1;
          if (down) begin
            if (m_t == 0) m_done = 1;
            else begin
              m_t = m_t - 1;
              if (m_t == 0) m_done = 1;
            end
          end else begin
            m_t = (m_t + 1) % MAXCS;
          end
        end
        if (edge_seen) begin
          if (m_laps.size() < N_LAPS) m_laps.push_back(old_t);
          else m_ovf = 1;
        end
      end
    end
    @(posedge clk_milisec);
    @(negedge clk_milisec);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; en = 0; down = 0; load = 0; split = 0; view = 0; preset = 0; lap_sel = 0;
    cycle(); cycle();
    n_cmp++; if (o_time !== 32'h0) begin n_fail++; $display("FAIL reset_time got %h want %h", o_time, 32'h0); end
    n_cmp++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL reset_lap_count got %0d want 0", lap_count); end
    n_cmp++; if ({lap_full, lap_ovf, done, tick} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {lap_full, lap_ovf, done, tick}); end
    rst = 0;
  endtask

  task automatic test_count_up();
    int ticks = 0;
    en = 1; down = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (tick === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 10) begin n_fail++; $display("FAIL count_up_ticks got %0d want 10", ticks); end
    n_cmp++; if (o_time !== 32'h00000010) begin n_fail++; $display("FAIL count_up_time got %h want %h", o_time, 32'h00000010); end
    n_cmp++; if (o_time !== exp_disp()) begin n_fail++; $display("FAIL count_up_model got %h want %h", o_time, exp_disp()); end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    load = 1; preset = 32'h99595999; en = 1; down = 0;
    cycle();
    load = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (tick === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL wrap_tick got none want 1 within 20 cycles"); end
    n_cmp++; if (o_time !== 32'h0) begin n_fail++; $display("FAIL wrap_time got %h want %h", o_time, 32'h0); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_done got %b want 0", done); end
  endtask

  task automatic test_countdown();
    logic [31:0] exp_t [3];
    logic        exp_d [3];
    bit          seen;
    exp_t = '{32'h1, 32'h0, 32'h0};
    exp_d = '{1'b0, 1'b1, 1'b1};
    load = 1; preset = 32'h00000002; down = 1; en = 1;
    cycle();
    load = 0;
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        cycle();
        if (tick === 1'b1) seen = 1;
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL down_tick%0d got none want 1", k); end
      n_cmp++; if (o_time !== exp_t[k]) begin n_fail++; $display("FAIL down_time%0d got %h want %h", k, o_time, exp_t[k]); end
      n_cmp++; if (done !== exp_d[k]) begin n_fail++; $display("FAIL down_done%0d got %b want %b", k, done, exp_d[k]); end
    end
    load = 1; preset = 32'h00000500;
    cycle();
    load = 0;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_clears_done got %b want 0", done); end
    n_cmp++; if (o_time !== 32'h00000500) begin n_fail++; $display("FAIL load_time got %h want %h", o_time, 32'h00000500); end
  endtask

  task automatic test_laps();
    logic [31:0] cap[$];
    load = 1; preset = 32'h0; down = 0; en = 1; view = 0; split = 0;
    cycle();
    load = 0;
    for (int l = 0; l < 5; l++) begin
      int gap = $urandom_range(3, 12);
      for (int g = 0; g < gap; g++) cycle();
      split = 1;
      cap.push_back(cs2bcd(m_t));
      n_cmp++; if (o_time !== cs2bcd(m_t)) begin n_fail++; $display("FAIL lap_edge_time%0d got %h want %h", l, o_time, cs2bcd(m_t)); end
      cycle();
      split = 0;
      cycle();
    end
    n_cmp++; if (lap_count !== 3'd4) begin n_fail++; $display("FAIL laps_count got %0d want 4", lap_count); end
    n_cmp++; if (lap_full !== 1'b1) begin n_fail++; $display("FAIL laps_full got %b want 1", lap_full); end
    n_cmp++; if (lap_ovf !== 1'b1) begin n_fail++; $display("FAIL laps_ovf got %b want 1", lap_ovf); end
    view = 1;
    for (int i = 0; i < 4; i++) begin
      lap_sel = 2'(i);
      #1;
      n_cmp++; if (o_time !== cap[i]) begin n_fail++; $display("FAIL lap_value%0d got %h want %h", i, o_time, cap[i]); end
    end
    view = 0;
  endtask

  task automatic test_tick_split();
    int guard = 0;
    load = 1; preset = 32'h00000009; down = 0; en = 1; split = 0; view = 0;
    cycle();
    load = 0;
    while (m_presc != CLK_DIV - 1 && guard < 10) begin cycle(); guard++; end
    split = 1;
    cycle();
    split = 0;
    view = 1; lap_sel = 0; #1;
    n_cmp++; if (o_time !== 32'h00000009) begin n_fail++; $display("FAIL tick_split_lap got %h want %h", o_time, 32'h00000009); end
    view = 0; #1;
    n_cmp++; if (o_time !== 32'h00000010) begin n_fail++; $display("FAIL tick_split_time got %h want %h", o_time, 32'h00000010); end
    cycle();
    load = 1; preset = 32'h00000005; split = 1;
    cycle();
    load = 0; split = 0;
    cycle();
    n_cmp++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL load_split_count got %0d want 0", lap_count); end
    n_cmp++; if (lap_ovf !== 1'b0) begin n_fail++; $display("FAIL load_split_ovf got %b want 0", lap_ovf); end
  endtask

  task automatic test_view_empty();
    load = 1; preset = 32'h00012345; en = 1; down = 0; split = 0; view = 0;
    cycle();
    load = 0;
    split = 1; cycle(); split = 0; cycle(); cycle(); cycle();
    split = 1; cycle(); split = 0; cycle();
    n_cmp++; if (lap_count !== 3'd2) begin n_fail++; $display("FAIL view_count got %0d want 2", lap_count); end
    view = 1; lap_sel = 3; #1;
    n_cmp++; if (o_time !== 32'h0) begin n_fail++; $display("FAIL view_sel3 got %h want %h", o_time, 32'h0); end
    lap_sel = 2; #1;
    n_cmp++; if (o_time !== 32'h0) begin n_fail++; $display("FAIL view_sel2 got %h want %h", o_time, 32'h0); end
    lap_sel = 1; #1;
    n_cmp++; if (o_time !== exp_disp()) begin n_fail++; $display("FAIL view_sel1 got %h want %h", o_time, exp_disp()); end
    lap_sel = 0; #1;
    n_cmp++; if (o_time !== 32'h00012345) begin n_fail++; $display("FAIL view_sel0 got %h want %h", o_time, 32'h00012345); end
    view = 0;
  endtask

  task automatic test_reset_mid();
    en = 1; down = 0; split = 0;
    cycle();
    split = 1;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1;
    cycle();
    n_cmp++; if (o_time !== 32'h0) begin n_fail++; $display("FAIL rstmid_time got %h want %h", o_time, 32'h0); end
    n_cmp++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", lap_count); end
    n_cmp++; if ({lap_ovf, done, tick} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got %b want 000", {lap_ovf, done, tick}); end
    rst = 0;
    for (int i = 0; i < 3; i++) cycle();
    n_cmp++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_spurious got %0d want 0", lap_count); end
    n_cmp++; if (o_time !== exp_disp()) begin n_fail++; $display("FAIL rstmid_time2 got %h want %h", o_time, exp_disp()); end
    split = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) down = ~down;
      load  = ($urandom_range(0, 119) == 0);
      preset = ($urandom_range(0, 1) == 0) ? cs2bcd($urandom_range(0, 300))
                                           : cs2bcd($urandom_range(0, MAXCS - 1));
      if ($urandom_range(0, 5) == 0) split = ~split;
      view    = $urandom_range(0, 1);
      lap_sel = 2'($urandom_range(0, 3));
      cycle();
      n_cmp++; if (o_time !== exp_disp()) begin n_fail++; $display("FAIL rand_time cyc=%0d got %h want %h", c, o_time, exp_disp()); end
      n_cmp++; if (lap_count !== 3'(m_laps.size())) begin n_fail++; $display("FAIL rand_count cyc=%0d got %0d want %0d", c, lap_count, m_laps.size()); end
      n_cmp++; if (lap_full !== (m_laps.size() == N_LAPS)) begin n_fail++; $display("FAIL rand_full cyc=%0d got %b", c, lap_full); end
      n_cmp++; if (lap_ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc=%0d got %b want %b", c, lap_ovf, m_ovf); end
      n_cmp++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done cyc=%0d got %b want %b", c, done, m_done); end
      n_cmp++; if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cyc=%0d got %b want %b", c, tick, m_tick); end
    end
    rst = 0; load = 0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_laps();
    test_tick_split();
    test_view_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout got no completion want finish before 2000000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
